// File: rtl/uart_dmi_bridge.sv
// UART-to-DMI command bridge: parses READ/WRITE frames from the RX FIFO,
// issues one DMI request per frame and returns status/data bytes to the TX FIFO.
module uart_dmi_bridge #(
  parameter int ABITS          = 7,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             RX_EMPTY_I,
  input  logic [7:0]       RX_DATA_I,
  output logic             RX_RE_O,
  input  logic             TX_READY_I,
  output logic             TX_WE_O,
  output logic [7:0]       TX_DATA_O,
  output logic             DMI_REQ_VALID_O,
  input  logic             DMI_REQ_READY_I,
  output logic [1:0]       DMI_REQ_OP_O,
  output logic [ABITS-1:0] DMI_REQ_ADDR_O,
  output logic [31:0]      DMI_REQ_DATA_O,
  input  logic             DMI_RESP_VALID_I,
  output logic             DMI_RESP_READY_O,
  input  logic [1:0]       DMI_RESP_OP_I,
  input  logic [31:0]      DMI_RESP_DATA_I,
  output logic             FRAME_ERR_O
);

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_WRITE  = 2'd2;

  // Counter only ever needs to hold TIMEOUT_CYCLES-1 before expiry.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_REQ,
    S_WAIT,
    S_TX_STAT,
    S_TX_DATA,
    S_TX_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       resp_op_q, resp_op_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             run_q, run_d;

  logic             rx_re;
  logic             tx_we;
  logic [7:0]       tx_byte;
  logic             frame_err;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_op_d   = resp_op_q;
    resp_data_d = resp_data_q;
    tmo_d       = '0;
    run_d       = 1'b1;
    rx_re       = 1'b0;
    tx_we       = 1'b0;
    tx_byte     = 8'h00;
    frame_err   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // run_q keeps the RX pop low while reset is asserted.
        rx_re = run_q & ~RX_EMPTY_I;
        if (rx_re) begin
          if (RX_DATA_I == CMD_READ) begin
            op_d    = OP_READ;
            data_d  = '0;
            state_d = S_ADDR;
          end else if (RX_DATA_I == CMD_WRITE) begin
            op_d    = OP_WRITE;
            data_d  = '0;
            state_d = S_ADDR;
          end else begin
            frame_err = 1'b1;
            state_d   = S_TX_ERR;
          end
        end
      end

      S_ADDR: begin
        rx_re = ~RX_EMPTY_I;
        if (rx_re) begin
          addr_d = RX_DATA_I[ABITS-1:0];
          cnt_d  = 2'd0;
          state_d = (op_q == OP_WRITE) ? S_DATA : S_REQ;
        end
      end

      S_DATA: begin
        rx_re = ~RX_EMPTY_I;
        if (rx_re) begin
          data_d[{cnt_q, 3'b000} +: 8] = RX_DATA_I;
          if (cnt_q == 2'd3) begin
            state_d = S_REQ;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      S_REQ: begin
        if (DMI_REQ_READY_I) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (DMI_RESP_VALID_I) begin
          resp_op_d   = DMI_RESP_OP_I;
          resp_data_d = DMI_RESP_DATA_I;
          state_d     = S_TX_STAT;
        end
      end

      S_TX_STAT: begin
        tx_byte = {6'b0, resp_op_q};
        tx_we   = TX_READY_I;
        if (tx_we) begin
          cnt_d   = 2'd0;
          state_d = (op_q == OP_WRITE) ? S_IDLE : S_TX_DATA;
        end
      end

      S_TX_DATA: begin
        tx_byte = resp_data_q[{cnt_q, 3'b000} +: 8];
        tx_we   = TX_READY_I;
        if (tx_we) begin
          if (cnt_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      S_TX_ERR: begin
        tx_byte = 8'hFF;
        tx_we   = TX_READY_I;
        if (tx_we) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout; a pop in the same cycle wins because rx_re blocks it.
    if ((TIMEOUT_CYCLES > 0) && ((state_q == S_ADDR) || (state_q == S_DATA)) && !rx_re) begin
      if (tmo_q == TMO_LAST) begin
        frame_err = 1'b1;
        state_d   = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_op_q   <= '0;
      resp_data_q <= '0;
      tmo_q       <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      resp_op_q   <= resp_op_d;
      resp_data_q <= resp_data_d;
      tmo_q       <= tmo_d;
      run_q       <= run_d;
    end
  end

  assign RX_RE_O          = rx_re;
  assign TX_WE_O          = tx_we;
  assign TX_DATA_O        = tx_byte;
  assign FRAME_ERR_O      = frame_err;
  assign DMI_REQ_VALID_O  = (state_q == S_REQ);
  assign DMI_REQ_OP_O     = op_q;
  assign DMI_REQ_ADDR_O   = addr_q;
  assign DMI_REQ_DATA_O   = data_q;
  assign DMI_RESP_READY_O = (state_q == S_WAIT);

endmodule

// File: tb/tb_uart_dmi_bridge.sv
// Directed self-checking bench for uart_dmi_bridge: models the RX FIFO,
// captures TX bytes and DMI requests, and plays the DMI responder.
module tb_uart_dmi_bridge;

  localparam int ABITS = 7;
  localparam int TMO   = 50;

  logic             clk        = 1'b0;
  logic             rst        = 1'b1;
  logic             rx_empty   = 1'b1;
  logic [7:0]       rx_data    = 8'h00;
  logic             tx_ready   = 1'b1;
  logic             req_ready  = 1'b1;
  logic             resp_valid = 1'b0;
  logic [1:0]       resp_op    = 2'd0;
  logic [31:0]      resp_data  = 32'h0;

  logic             rx_re, tx_we, req_valid, resp_ready, frame_err;
  logic [7:0]       tx_data;
  logic [1:0]       req_op;
  logic [ABITS-1:0] req_addr;
  logic [31:0]      req_data;

  always #5 clk = ~clk;

  uart_dmi_bridge #(.ABITS(ABITS), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK_I            (clk),
    .RST_I            (rst),
    .RX_EMPTY_I       (rx_empty),
    .RX_DATA_I        (rx_data),
    .RX_RE_O          (rx_re),
    .TX_READY_I       (tx_ready),
    .TX_WE_O          (tx_we),
    .TX_DATA_O        (tx_data),
    .DMI_REQ_VALID_O  (req_valid),
    .DMI_REQ_READY_I  (req_ready),
    .DMI_REQ_OP_O     (req_op),
    .DMI_REQ_ADDR_O   (req_addr),
    .DMI_REQ_DATA_O   (req_data),
    .DMI_RESP_VALID_I (resp_valid),
    .DMI_RESP_READY_O (resp_ready),
    .DMI_RESP_OP_I    (resp_op),
    .DMI_RESP_DATA_I  (resp_data),
    .FRAME_ERR_O      (frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RX FIFO model: main pushes into rx_mem, this process pops after each edge.
  logic [7:0] rx_mem [64];
  int         rx_wr    = 0;
  int         rx_rd    = 0;
  logic       pop_pend = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend) rx_rd++;
      rx_empty = (rx_rd == rx_wr);
      rx_data  = rx_mem[rx_rd % 64];
    end
  end

  task automatic rx_push(input logic [7:0] b);
    rx_mem[rx_wr % 64] = b;
    rx_wr++;
  endtask

  // Monitor: everything is sampled on the falling edge.
  logic [7:0]       tx_log     [64];
  int               tx_cyc_log [64];
  int               tx_n = 0;
  logic [1:0]       req_op_log   [16];
  logic [ABITS-1:0] req_addr_log [16];
  logic [31:0]      req_data_log [16];
  int               req_n = 0;
  int               err_n = 0, err_cyc = 0, last_pop_cyc = 0;
  int               valid_rise_cyc = 0, resp_hs_cyc = 0;
  int               stab_bad = 0, stall_n = 0;
  logic             prev_valid = 1'b0, stalled_prev = 1'b0;
  logic [40:0]      prev_fields = '0;

  always @(negedge clk) begin
    pop_pend = rx_re;
    if (rx_re) last_pop_cyc = cyc;
    if (tx_we) begin
      tx_log[tx_n % 64]     = tx_data;
      tx_cyc_log[tx_n % 64] = cyc;
      tx_n++;
    end
    if (frame_err) begin
      err_n++;
      err_cyc = cyc;
    end
    if (req_valid && !prev_valid) valid_rise_cyc = cyc;
    if (req_valid && req_ready) begin
      req_op_log[req_n % 16]   = req_op;
      req_addr_log[req_n % 16] = req_addr;
      req_data_log[req_n % 16] = req_data;
      req_n++;
    end
    if (resp_valid && resp_ready) resp_hs_cyc = cyc;
    if (stalled_prev && (!req_valid || ({req_op, req_addr, req_data} != prev_fields))) stab_bad++;
    if (req_valid && !req_ready) stall_n++;
    stalled_prev = req_valid && !req_ready;
    prev_fields  = {req_op, req_addr, req_data};
    prev_valid   = req_valid;
  end

  task automatic wait_req(input string tag, input int n_exp);
    for (int i = 0; i < 200 && req_n < n_exp; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_req_count"}, req_n, n_exp);
  endtask

  task automatic respond(input string tag, input logic [1:0] op, input logic [31:0] data);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    resp_valid = 1'b1;
    resp_op    = op;
    resp_data  = data;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
    resp_op    = 2'd0;
    resp_data  = 32'h0;
    check({tag, "_resp_handshake"}, ok, 1);
  endtask

  task automatic wait_tx(input string tag, input int n_exp, input bit toggle);
    for (int i = 0; i < 300 && tx_n < n_exp; i++) begin
      @(posedge clk);
      #1;
      if (toggle) tx_ready = ~tx_ready;
      @(negedge clk);
      #1;
    end
    tx_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_tx_count"}, tx_n, n_exp);
  endtask

  task automatic check_tx(input string tag, input int base, input int n, input logic [39:0] exp);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_tx%0d", tag, k), tx_log[(base + k) % 64], exp[8*k +: 8]);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {10'b0, rx_re, tx_we, tx_data, req_valid, req_op, req_addr, req_data, resp_ready, frame_err};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int err0;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outputs(), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: write 0x12345678 to 0x05
    rx_push(8'h02); rx_push(8'h05); rx_push(8'h78);
    rx_push(8'h56); rx_push(8'h34); rx_push(8'h12);
    wait_req("t1", 1);
    check("t1_op",   req_op_log[0],   2'd2);
    check("t1_addr", req_addr_log[0], 7'h05);
    check("t1_data", req_data_log[0], 32'h12345678);
    respond("t1", 2'd0, 32'h0);
    wait_tx("t1", 1, 1'b0);
    check_tx("t1", 0, 1, 40'h00);

    // 2: read 0x11 returning 0xDEADBEEF
    rx_push(8'h01); rx_push(8'h11);
    wait_req("t2", 2);
    check("t2_op",   req_op_log[1],   2'd1);
    check("t2_addr", req_addr_log[1], 7'h11);
    check("t2_data", req_data_log[1], 32'h0);
    check("t2_req_latency", valid_rise_cyc - last_pop_cyc, 1);
    respond("t2", 2'd0, 32'hDEADBEEF);
    wait_tx("t2", 6, 1'b0);
    check("t2_tx_latency", tx_cyc_log[1] - resp_hs_cyc, 1);
    check_tx("t2", 1, 5, 40'hDEADBEEF00);

    // 3: unknown command, then a normal read
    err0 = err_n;
    rx_push(8'h7A);
    wait_tx("t3err", 7, 1'b0);
    check_tx("t3err", 6, 1, 40'hFF);
    check("t3_err_pulses", err_n - err0, 1);
    check("t3_no_req", req_n, 2);
    rx_push(8'h01); rx_push(8'h00);
    wait_req("t3", 3);
    check("t3_op",   req_op_log[2],   2'd1);
    check("t3_addr", req_addr_log[2], 7'h00);
    respond("t3", 2'd0, 32'h04030201);
    wait_tx("t3", 12, 1'b0);
    check_tx("t3", 7, 5, 40'h0403020100);

    // 4: truncated write frame times out
    err0 = err_n;
    rx_push(8'h02); rx_push(8'h05); rx_push(8'hAA);
    for (int i = 0; i < 200 && err_n == err0; i++) begin
      @(negedge clk);
      #1;
    end
    check("t4_err_pulses", err_n - err0, 1);
    check("t4_err_delay", err_cyc - last_pop_cyc, TMO);
    repeat (5) @(posedge clk);
    #1;
    check("t4_no_req", req_n, 3);
    check("t4_no_tx", tx_n, 12);
    rx_push(8'h01); rx_push(8'h03);
    wait_req("t4", 4);
    check("t4_op",   req_op_log[3],   2'd1);
    check("t4_addr", req_addr_log[3], 7'h03);
    respond("t4", 2'd2, 32'h55AA55AA);
    wait_tx("t4", 17, 1'b0);
    check_tx("t4", 12, 5, 40'h55AA55AA02);

    // 5: DMI request backpressure and toggling TX readiness
    req_ready = 1'b0;
    stall_n   = 0;
    rx_push(8'h01); rx_push(8'h22);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (req_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_valid_seen", seen, 1);
    repeat (10) @(posedge clk);
    #1;
    req_ready = 1'b1;
    wait_req("t5", 5);
    check("t5_stall_cycles", stall_n, 10);
    check("t5_stable", stab_bad, 0);
    check("t5_op",   req_op_log[4],   2'd1);
    check("t5_addr", req_addr_log[4], 7'h22);
    respond("t5", 2'd0, 32'hCAFEF00D);
    wait_tx("t5", 22, 1'b1);
    check_tx("t5", 17, 5, 40'hCAFEF00D00);

    // 6: reset while waiting for the DMI response
    rx_push(8'h01); rx_push(8'h40);
    wait_req("t6a", 6);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (resp_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_in_wait", seen, 1);
    rst = 1'b1;
    #1;
    check("t6_async_reset_outputs", all_outputs(), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    resp_valid = 1'b1;
    resp_op    = 2'd0;
    resp_data  = 32'h00000BAD;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_ready) seen = 1'b1;
    end
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    check("t6_late_resp_ignored", seen, 0);
    check("t6_no_tx_after_reset", tx_n, 22);
    rx_push(8'h01); rx_push(8'h02);
    wait_req("t6", 7);
    check("t6_op",   req_op_log[6],   2'd1);
    check("t6_addr", req_addr_log[6], 7'h02);
    respond("t6", 2'd0, 32'h0BADF00D);
    wait_tx("t6", 27, 1'b0);
    check_tx("t6", 22, 5, 40'h0BADF00D00);

    check("total_frame_errors", err_n, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
